// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receive path.
// Holds the framer state encoding and counter width functions.
package uart_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    CLOSE   = 2'd2
  } uart_framer_state_t;

  // Bits needed to count 0..n inclusive (frame length).
  function automatic int len_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to count 0..n-1 (idle clocks).
  function automatic int idle_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Idle/quiet-line timer: counts enabled clocks, flags CYCLES-1 reached.
// Ports: clk_i, rst_i (sync, high), clear_i, enable_i, expired_o.
module uart_idle_timer
  import uart_pkg::*;
#(
  parameter int CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = idle_w(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  assign expired_o = (cnt == LAST);

  // Saturates at LAST so a held enable never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (enable_i && !expired_o) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Groups received UART bytes into frames, marking tlast on the final byte.
// Ports: clk_i, rst_i (sync, high); slv_axis_* byte stream in;
// mst_axis_* framed stream out; timeout_o pulses on idle close.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IDLE_CYCLES = 1000,
  parameter int MAX_LEN     = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] slv_axis_tdata_i,
  input  logic                  slv_axis_tvalid_i,
  input  logic                  slv_axis_tlast_i,
  output logic                  slv_axis_tready_o,
  output logic [DATA_WIDTH-1:0] mst_axis_tdata_o,
  output logic                  mst_axis_tvalid_o,
  output logic                  mst_axis_tlast_o,
  input  logic                  mst_axis_tready_i,
  output logic                  timeout_o
);

  localparam int LW = len_w(MAX_LEN);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam bit ONE_BYTE = (MAX_LEN == 1);

  uart_framer_state_t state, state_d;

  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_v;
  logic [LW-1:0]         len;

  logic          out_free;
  logic          accept;
  logic          first_final;
  logic          next_final;
  logic [LW-1:0] len_inc;
  logic          expired;

  logic          hold_load;
  logic          hold_last_d;
  logic          out_load;
  logic          out_last_d;
  logic [LW-1:0] len_d;
  logic          idle_clr;
  logic          idle_en;
  logic          timeout_d;

  assign out_free = !out_v || mst_axis_tready_i;

  assign slv_axis_tready_o =
    !rst_i && ((state == EMPTY) || out_free);

  assign accept = slv_axis_tvalid_i && slv_axis_tready_o;

  assign len_inc = len + 1'b1;

  // A byte opening a frame is final on tlast or a 1-byte limit.
  assign first_final = slv_axis_tlast_i || ONE_BYTE;
  assign next_final  = slv_axis_tlast_i || (len_inc == LEN_MAX);

  uart_idle_timer #(
    .CYCLES (IDLE_CYCLES)
  ) u_idle (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (idle_clr),
    .enable_i  (idle_en),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_d = first_final ? CLOSE : COLLECT;
        end
      end
      COLLECT: begin
        // An accept in the expiry cycle wins over the timeout.
        if (accept) begin
          state_d = next_final ? CLOSE : COLLECT;
        end else if (expired) begin
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (out_free) begin
          if (accept) begin
            state_d = first_final ? CLOSE : COLLECT;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    hold_load   = 1'b0;
    hold_last_d = hold_last;
    out_load    = 1'b0;
    out_last_d  = 1'b0;
    len_d       = len;
    idle_clr    = 1'b1;
    idle_en     = 1'b0;
    timeout_d   = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          hold_load   = 1'b1;
          hold_last_d = first_final;
          len_d       = LEN_ONE;
        end
      end
      COLLECT: begin
        idle_clr = 1'b0;
        if (accept) begin
          out_load    = 1'b1;
          hold_load   = 1'b1;
          hold_last_d = next_final;
          len_d       = len_inc;
          idle_clr    = 1'b1;
        end else if (expired) begin
          hold_last_d = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          idle_en = 1'b1;
        end
      end
      CLOSE: begin
        if (out_free) begin
          out_load   = 1'b1;
          out_last_d = 1'b1;
          if (accept) begin
            hold_load   = 1'b1;
            hold_last_d = first_final;
            len_d       = LEN_ONE;
          end else begin
            len_d = '0;
          end
        end
      end
      default: begin
        hold_last_d = 1'b0;
        len_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_data <= '0;
      hold_last <= 1'b0;
      len       <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (hold_load) begin
        hold_data <= slv_axis_tdata_i;
      end
      hold_last <= hold_last_d;
      len       <= len_d;
      timeout_o <= timeout_d;
    end
  end

  // out_load only occurs with out_free, so a stalled beat is kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data <= '0;
      out_last <= 1'b0;
      out_v    <= 1'b0;
    end else if (out_load) begin
      out_data <= hold_data;
      out_last <= out_last_d;
      out_v    <= 1'b1;
    end else if (mst_axis_tready_i) begin
      out_v <= 1'b0;
    end
  end

  assign mst_axis_tdata_o  = out_data;
  assign mst_axis_tlast_o  = out_last;
  assign mst_axis_tvalid_o = out_v;

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Receive-path stage directly downstream of the UART receiver's byte-wide AXI-Stream master. It groups the received bytes into frames for the consumer. A frame ends when the receiver asserts tlast, when the line has been idle for a programmable number of clocks, or when the frame reaches a maximum length. It places tlast on the final byte of each frame, which requires holding back one byte, and passes backpressure through to the receiver.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width on both streams
- IDLE_CYCLES, 1000, number of clocks with no input that closes the open frame; legal range ≥2
- MAX_LEN, 64, maximum bytes per frame; the frame is forced closed at this length; legal range ≥1

Ports:
- clk_i  in  1  system clock; the block uses one clock domain
- rst_i  in  1  reset; synchronous, active-high
- slv_axis_tdata_i  in  DATA_WIDTH  received byte from the UART receiver
- slv_axis_tvalid_i  in  1  byte valid
- slv_axis_tlast_i  in  1  upstream end-of-frame; when high, the accepted byte closes the frame
- slv_axis_tready_o  out  1  framer can accept a byte
- mst_axis_tdata_o  out  DATA_WIDTH  framed byte
- mst_axis_tvalid_o  out  1  framed byte valid
- mst_axis_tlast_o  out  1  last byte of the frame
- mst_axis_tready_i  in  1  consumer ready
- timeout_o  out  1  one-cycle pulse when a frame is closed by the idle timeout

## Operation
Storage:
- Hold register: hold_data, hold_last, and a valid bit derived from the state.
- Output register: out_data, out_last, out_v. These drive the mst_axis_* ports directly.
- Length counter len, range 0..MAX_LEN.
- Idle counter, range 0..IDLE_CYCLES-1.

Handshake signals:
- out_free = !out_v || mst_axis_tready_i
- slv_axis_tready_o = (state == EMPTY) || out_free; it is forced to 0 while rst_i is high.
- accept = slv_axis_tvalid_i && slv_axis_tready_o

State machine (uart_framer_state_t):
- EMPTY: hold register is empty. On accept, the byte goes to hold and len becomes 1. The byte is final if slv_axis_tlast_i is high or MAX_LEN == 1; then go to CLOSE, otherwise go to COLLECT.
- COLLECT: hold register contains a non-final byte.
  - On accept, move hold to the output register with out_last=0, load the new byte into hold, increment len, and clear the idle counter. The new byte is final if its tlast is high or the new len == MAX_LEN; then go to CLOSE.
  - With no accept, the idle counter increments. When it equals IDLE_CYCLES-1, set hold_last=1, pulse timeout_o, and go to CLOSE.
  - If an accept occurs in the same cycle the timeout would fire, the accept wins: the byte is appended and there is no timeout.
- CLOSE: hold register contains the final byte.
  - When out_free is high, move hold to the output register with out_last=1.
  - If an accept happens in the same cycle, the new byte opens a new frame in hold with len=1. Its finality is judged as in EMPTY. Otherwise go to EMPTY with len=0.

Output register:
- Loaded only when out_free is high.
- out_v clears when mst_axis_tready_i is high and nothing new is loaded.
- The output is never overwritten while out_v && !mst_axis_tready_i.

No byte is ever dropped, and byte order is preserved.

## Timing
- All registers and outputs reset to 0 at the clock edge where rst_i is high. State resets to EMPTY.
- Reset in the middle of a frame discards the held byte and the output byte. The first byte after reset starts a new frame.
- Throughput is one byte per clock when mst_axis_tready_i stays high.
- Latency for a byte accepted at edge E that is not final:
  - It appears at the output after the edge at which the next byte is accepted, or
  - at the edge after the timeout fires, which is E+IDLE_CYCLES+1 with no further input.
- Latency for a byte that is final at acceptance (upstream tlast or length limit) and with out_free high: it is moved to the output at edge E+1, so tvalid and tlast are high in the cycle after E+1.
- timeout_o is high during the single cycle following edge E+IDLE_CYCLES.

## Structure
- Package uart_pkg holds:
  - the typedef uart_framer_state_t {EMPTY, COLLECT, CLOSE}
  - the localparam functions for counter widths: $clog2(MAX_LEN+1) and $clog2(IDLE_CYCLES)
- One sub-module, uart_idle_timer. It has clear and enable inputs and an expired output that is high when the count equals IDLE_CYCLES-1. It is also reused for the break-detect logic.

## Test plan
All scenarios use IDLE_CYCLES=16 and MAX_LEN=4.
- Single byte: send 0x5A, then silence -> one output beat 0x5A with tlast=1. timeout_o pulses exactly 16 cycles after the accept, and the output is valid on the following cycle.
- Length limit: send 0x01..0x06 back-to-back with the consumer always ready -> frames [01 02 03 04↓] and [05 06↓], where ↓ marks tlast=1. The second frame closes by timeout, and tready_o is never low.
- Upstream tlast: send 0xA0 and 0xA1 with tlast on 0xA1, then 0xB0 immediately after -> 0xA1 has tlast=1, 0xB0 starts a new frame, and there is no timeout pulse for the first frame.
- Backpressure: hold mst_axis_tready_i low for 10 cycles while sending 0x10, 0x11, 0x12 -> tready_o drops once hold and output are both full. After release, all bytes come out in order with none lost, and tdata is stable while stalled.
- Race: a byte arrives exactly in the cycle where the idle counter reaches 15 -> the byte is appended to the current frame, and there is no timeout_o pulse.
- Reset mid-frame: assert rst_i after 0x33 is accepted -> all outputs are 0. The next byte 0x44 followed by silence yields the single frame [44↓].
